regfile_reader: RTL and testbench

REGFILE_READER -- requirements
Module: regfile_reader

---
 rtl/regfile_pkg.sv | 9 +
 rtl/rd_parity.sv | 9 +
 rtl/regfile_reader.sv | 81 ++++++++
 tb/tb_regfile_reader.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared FSM encoding and sizing constants for regfile_reader
package regfile_pkg;
    localparam int ADDR_W      = 2;
    localparam int BURST_BEATS = 4;
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] SEND   = 2'd2;
    typedef logic [ADDR_W-1:0] addr_t;
endpackage

// File: rtl/rd_parity.sv
// rd_parity: even parity (XOR-reduce) of a data word
module rd_parity #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] data,
    output logic              parity
);
    assign parity = ^data;
endmodule

// File: rtl/regfile_reader.sv
// regfile_reader: single/4-beat burst reader driving a register file mux.
// Define REGFILE_READER_PARITY_EN to add the registered out_parity output.
module regfile_reader
    import regfile_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NREGS  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic [1:0]        req_addr,
    input  logic              req_burst,
    output logic              req_ready,
    output logic [1:0]        sel,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready
`ifdef REGFILE_READER_PARITY_EN
    ,
    output logic              out_parity
`endif
);
    logic [1:0] state;
    addr_t      addr;
    addr_t      cnt;
    addr_t      next_addr;

    assign next_addr = (addr == ADDR_W'(NREGS - 1)) ? '0 : addr + 1'b1;
    assign req_ready = state == IDLE;
    assign sel       = addr;
    assign out_valid = state == SEND;
    assign out_last  = out_valid && cnt == '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            addr     <= '0;
            cnt      <= '0;
            out_data <= '0;
        end else begin
            case (state)
                IDLE: if (req) begin
                    addr  <= req_addr;
                    cnt   <= req_burst ? ADDR_W'(BURST_BEATS - 1) : '0;
                    state <= SETTLE;
                end
                SETTLE: begin
                    out_data <= rd_data;
                    state    <= SEND;
                end
                SEND: if (out_ready) begin
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        addr  <= next_addr;
                        cnt   <= cnt - 1'b1;
                        state <= SETTLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef REGFILE_READER_PARITY_EN
    logic rd_par;

    rd_parity #(.DATA_W(DATA_W)) u_par (.data(rd_data), .parity(rd_par));

    // Captured alongside out_data so it holds under the same stall rules
    always_ff @(posedge clk) begin
        if (reset)
            out_parity <= 1'b0;
        else if (state == SETTLE)
            out_parity <= rd_par;
    end
`endif
endmodule

// File: tb/tb_regfile_reader.sv
// tb_regfile_reader: table-driven and directed self-checking bench for regfile_reader
module tb_regfile_reader;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req = 1'b0;
    logic [1:0] req_addr = '0;
    logic       req_burst = 1'b0;
    logic       req_ready;
    logic [1:0] sel;
    logic [7:0] rd_data;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic       out_ready = 1'b1;
`ifdef REGFILE_READER_PARITY_EN
    logic       out_parity;
`endif

    logic [7:0] rf [4];
    logic       ovr = 1'b0;
    logic [7:0] rnd = '0;
    int         n_cmp = 0;
    int         n_bad = 0;

    assign rd_data = ovr ? rnd : rf[sel];

    always #5 clk = ~clk;

    regfile_reader #(.DATA_W(8), .NREGS(4)) dut (
        .clk(clk), .reset(reset), .req(req), .req_addr(req_addr),
        .req_burst(req_burst), .req_ready(req_ready), .sel(sel),
        .rd_data(rd_data), .out_data(out_data), .out_valid(out_valid),
        .out_last(out_last), .out_ready(out_ready)
`ifdef REGFILE_READER_PARITY_EN
        , .out_parity(out_parity)
`endif
    );

    typedef struct {
        logic [1:0]  addr;
        logic        burst;
        int          beats;
        logic [31:0] data;
        logic [7:0]  sels;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        vec_t vecs [5];
        rf[0] = 8'h11; rf[1] = 8'h22; rf[2] = 8'h33; rf[3] = 8'h44;
        vecs[0] = '{2'd2, 1'b0, 1, 32'h00000033, 8'b00_00_00_10};
        vecs[1] = '{2'd3, 1'b1, 4, 32'h33221144, 8'b10_01_00_11};
        vecs[2] = '{2'd0, 1'b1, 4, 32'h44332211, 8'b11_10_01_00};
        vecs[3] = '{2'd1, 1'b0, 1, 32'h00000022, 8'b00_00_00_01};
        vecs[4] = '{2'd2, 1'b1, 4, 32'h22114433, 8'b01_00_11_10};

        step();
        step();
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_sel", sel, 0);
        chk("rst_data", out_data, 0);
        chk("rst_ready", req_ready, 1);
        reset = 1'b0;
        step();

        for (int i = 0; i < 5; i++) begin
            req = 1'b1; req_addr = vecs[i].addr; req_burst = vecs[i].burst;
            chk("acc_ready", req_ready, 1);
            step();
            req = 1'b0;
            chk("settle_sel", sel, vecs[i].addr);
            chk("settle_valid", out_valid, 0);
            step();
            for (int b = 0; b < vecs[i].beats; b++) begin
                chk("beat_valid", out_valid, 1);
                chk("beat_data", out_data, vecs[i].data[8*b +: 8]);
                chk("beat_sel", sel, vecs[i].sels[2*b +: 2]);
                chk("beat_last", out_last, b == vecs[i].beats - 1);
                chk("beat_busy", req_ready, 0);
                step();
                chk("gap_valid", out_valid, 0);
                if (b < vecs[i].beats - 1) step();
            end
            chk("done_ready", req_ready, 1);
        end

        // Stalled single read with ignored requests and noisy rd_data
        req = 1'b1; req_addr = 2'd1; req_burst = 1'b0; out_ready = 1'b0;
        step();
        req_addr = 2'd3; req_burst = 1'b1;
        step();
        for (int k = 0; k < 5; k++) begin
            ovr = 1'b1; rnd = 8'($urandom);
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, 8'h22);
            chk("stall_last", out_last, 1);
            chk("stall_sel", sel, 1);
            chk("stall_ready", req_ready, 0);
            step();
        end
        ovr = 1'b0; req = 1'b0; out_ready = 1'b1;
        chk("rel_valid", out_valid, 1);
        chk("rel_data", out_data, 8'h22);
        step();
        chk("rel_idle_valid", out_valid, 0);
        chk("rel_idle_ready", req_ready, 1);
        chk("rel_idle_sel", sel, 1);

        // Reset during the second beat of a burst
        req = 1'b1; req_addr = 2'd0; req_burst = 1'b1;
        step();
        req = 1'b0;
        step();
        step();
        step();
        chk("b2_valid", out_valid, 1);
        chk("b2_data", out_data, 8'h22);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_sel", sel, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_ready", req_ready, 1);
        req = 1'b1; req_addr = 2'd3; req_burst = 1'b0;
        step();
        req = 1'b0;
        step();
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_data", out_data, 8'h44);
        chk("post_rst_last", out_last, 1);
        step();
        chk("post_rst_idle", req_ready, 1);

`ifdef REGFILE_READER_PARITY_EN
        rf[0] = 8'h07;
        req = 1'b1; req_addr = 2'd0; req_burst = 1'b0;
        step();
        req = 1'b0;
        step();
        chk("par_07_data", out_data, 8'h07);
        chk("par_07", out_parity, 1);
        step();
        req = 1'b1; req_addr = 2'd2;
        step();
        req = 1'b0;
        step();
        chk("par_33_data", out_data, 8'h33);
        chk("par_33", out_parity, 0);
        step();
        rf[0] = 8'h11;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
